// File: rtl/request_unit_if.sv
// Handshake bundle between the control unit / memory side and the request
// sequencer. The slave modport is the sequencer's view of the bundle.
interface request_unit_if;
  // Control-unit decode and memory hit strobes
  logic iMemRe;
  logic dMemRe;
  logic dMemWr;
  logic Halt;
  logic iHit;
  logic dHit;
  // Sequencer outputs
  logic imemREN;
  logic dmemREN;
  logic dmemWEN;
  logic pcEn;
  logic halt;
  logic err;

  modport master (
    output iMemRe, dMemRe, dMemWr, Halt, iHit, dHit,
    input  imemREN, dmemREN, dmemWEN, pcEn, halt, err
  );

  modport slave (
    input  iMemRe, dMemRe, dMemWr, Halt, iHit, dHit,
    output imemREN, dmemREN, dmemWEN, pcEn, halt, err
  );
endinterface

// File: rtl/request_unit.sv
// Memory-request sequencer: one instruction fetch, then at most one data
// access per instruction. Each request is held until its hit; retirement is
// signalled by a single-cycle pcEn. Also counts stall cycles and flags hung
// (timed-out) or illegal (load+store) data requests.
module request_unit #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  request_unit_if.slave    bus,
  output logic [CNT_W-1:0] stall_cnt
);

  // Wait counter only needs to reach TIMEOUT-1; it parks there once err fires.
  localparam int              WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DATA   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_dmem_ren;
  logic              r_dmem_wen;
  logic              r_halt;
  logic              r_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [WAIT_W-1:0] r_wait;

  state_t            w_state_next;
  logic              w_dmem_ren_next;
  logic              w_dmem_wen_next;
  logic              w_halt_next;
  logic              w_err_next;
  logic              w_stall;
  logic [CNT_W-1:0]  w_stall_cnt_next;
  logic [WAIT_W-1:0] w_wait_next;
  logic              w_imem_ren;
  logic              w_pc_en;

  // State register; reset returns to FETCH regardless of where we are.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_FETCH;
    else     r_state <= w_state_next;
  end

  // Next-state, request and retirement decode.
  always_comb begin
    w_state_next    = r_state;
    w_dmem_ren_next = r_dmem_ren;
    w_dmem_wen_next = r_dmem_wen;
    w_halt_next     = r_halt;
    w_err_next      = r_err;
    w_wait_next     = r_wait;
    w_stall         = 1'b0;
    w_imem_ren      = 1'b0;
    w_pc_en         = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_imem_ren = bus.iMemRe;
        if (bus.iHit) begin
          if (bus.Halt) begin
            // HALT wins over any data op decoded alongside it.
            w_state_next = S_HALTED;
            w_halt_next  = 1'b1;
          end else if (bus.dMemWr) begin
            // Load+store together is illegal; it proceeds as a store.
            w_state_next    = S_DATA;
            w_dmem_wen_next = 1'b1;
            w_dmem_ren_next = 1'b0;
            if (bus.dMemRe) w_err_next = 1'b1;
          end else if (bus.dMemRe) begin
            w_state_next    = S_DATA;
            w_dmem_ren_next = 1'b1;
            w_dmem_wen_next = 1'b0;
          end else begin
            // No data phase: retire in the fetch-hit cycle.
            w_pc_en = 1'b1;
          end
        end else begin
          w_stall = bus.iMemRe;
        end
      end

      S_DATA: begin
        if (bus.dHit) begin
          w_pc_en         = 1'b1;
          w_dmem_ren_next = 1'b0;
          w_dmem_wen_next = 1'b0;
          w_wait_next     = '0;
          w_state_next    = S_FETCH;
        end else begin
          // Keep waiting even after the timeout is flagged; no abort.
          w_stall = 1'b1;
          if (r_wait == WAIT_LAST) w_err_next  = 1'b1;
          else                     w_wait_next = r_wait + WAIT_W'(1);
        end
      end

      S_HALTED: begin
        // Absorbing: nothing moves until reset.
      end

      default: begin
        w_state_next    = S_FETCH;
        w_dmem_ren_next = 1'b0;
        w_dmem_wen_next = 1'b0;
      end
    endcase

    // Saturating stall counter.
    if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
      w_stall_cnt_next = r_stall_cnt + CNT_W'(1);
    else
      w_stall_cnt_next = r_stall_cnt;
  end

  // Registered request lines, sticky flags and counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dmem_ren  <= 1'b0;
      r_dmem_wen  <= 1'b0;
      r_halt      <= 1'b0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
      r_wait      <= '0;
    end else begin
      r_dmem_ren  <= w_dmem_ren_next;
      r_dmem_wen  <= w_dmem_wen_next;
      r_halt      <= w_halt_next;
      r_err       <= w_err_next;
      r_stall_cnt <= w_stall_cnt_next;
      r_wait      <= w_wait_next;
    end
  end

  assign bus.imemREN = w_imem_ren;
  assign bus.dmemREN = r_dmem_ren;
  assign bus.dmemWEN = r_dmem_wen;
  assign bus.pcEn    = w_pc_en;
  assign bus.halt    = r_halt;
  assign bus.err     = r_err;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit, built with a small stall counter and a
// short timeout so saturation and the hung-request flag are reachable.
module tb_request_unit;
  localparam int CNT_W   = 2;
  localparam int TIMEOUT = 4;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] stall_cnt;
  int               tests;
  int               fails;

  request_unit_if bus_if ();

  request_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus_if),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ire, input logic dre, input logic dwr,
                        input logic hlt, input logic ih, input logic dh);
    bus_if.iMemRe = ire;
    bus_if.dMemRe = dre;
    bus_if.dMemWr = dwr;
    bus_if.Halt   = hlt;
    bus_if.iHit   = ih;
    bus_if.dHit   = dh;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    rst = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    tests++; if (bus_if.dmemREN !== 1'b0) begin fails++; $display("FAIL reset_dmemREN got %b want 0", bus_if.dmemREN); end
    tests++; if (bus_if.dmemWEN !== 1'b0) begin fails++; $display("FAIL reset_dmemWEN got %b want 0", bus_if.dmemWEN); end
    tests++; if (bus_if.halt !== 1'b0) begin fails++; $display("FAIL reset_halt got %b want 0", bus_if.halt); end
    tests++; if (bus_if.err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", bus_if.err); end
    tests++; if (stall_cnt !== 2'd0) begin fails++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
    tests++; if (bus_if.imemREN !== 1'b1) begin fails++; $display("FAIL reset_imemREN got %b want 1", bus_if.imemREN); end
    $display("[TB] reset transaction checked");
  endtask

  task automatic test_rtype();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #2;
      tests++; if (bus_if.pcEn !== 1'b1) begin fails++; $display("FAIL rtype_pcEn cyc %0d got %b want 1", k, bus_if.pcEn); end
      step();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    tests++; if (stall_cnt !== 2'd0) begin fails++; $display("FAIL rtype_stall got %0d want 0", stall_cnt); end
    tests++; if ({bus_if.dmemREN, bus_if.dmemWEN} !== 2'b00) begin fails++; $display("FAIL rtype_dmem got %b%b want 00", bus_if.dmemREN, bus_if.dmemWEN); end
    $display("[TB] rtype burst of 5 retired");
  endtask

  task automatic test_load();
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    tests++; if (bus_if.pcEn !== 1'b0) begin fails++; $display("FAIL load_pcEn_c0 got %b want 0", bus_if.pcEn); end
    step();
    for (int k = 1; k <= 3; k++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, (k == 3));
      #2;
      tests++; if (bus_if.dmemREN !== 1'b1) begin fails++; $display("FAIL load_dmemREN cyc %0d got %b want 1", k, bus_if.dmemREN); end
      tests++; if (bus_if.pcEn !== (k == 3)) begin fails++; $display("FAIL load_pcEn cyc %0d got %b want %b", k, bus_if.pcEn, (k == 3)); end
      if (k == 3) begin
        tests++; if (stall_cnt !== 2'd2) begin fails++; $display("FAIL load_stall got %0d want 2", stall_cnt); end
      end
      step();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    tests++; if (bus_if.imemREN !== 1'b1) begin fails++; $display("FAIL load_back_fetch got %b want 1", bus_if.imemREN); end
    tests++; if (bus_if.dmemREN !== 1'b0) begin fails++; $display("FAIL load_dmemREN_drop got %b want 0", bus_if.dmemREN); end
    $display("[TB] load transaction retired on dHit");
  endtask

  task automatic test_illegal_store();
    do_reset();
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    tests++; if (bus_if.err !== 1'b0) begin fails++; $display("FAIL ill_err_c0 got %b want 0", bus_if.err); end
    step();
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    tests++; if (bus_if.dmemWEN !== 1'b1) begin fails++; $display("FAIL ill_dmemWEN got %b want 1", bus_if.dmemWEN); end
    tests++; if (bus_if.dmemREN !== 1'b0) begin fails++; $display("FAIL ill_dmemREN got %b want 0", bus_if.dmemREN); end
    tests++; if (bus_if.err !== 1'b1) begin fails++; $display("FAIL ill_err got %b want 1", bus_if.err); end
    step();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    tests++; if (bus_if.pcEn !== 1'b1) begin fails++; $display("FAIL ill_pcEn got %b want 1", bus_if.pcEn); end
    step();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    tests++; if (bus_if.dmemWEN !== 1'b0) begin fails++; $display("FAIL ill_wen_drop got %b want 0", bus_if.dmemWEN); end
    tests++; if (bus_if.err !== 1'b1) begin fails++; $display("FAIL ill_err_sticky got %b want 1", bus_if.err); end
    $display("[TB] illegal load+store retired as store");
  endtask

  task automatic test_halt();
    do_reset();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    tests++; if (bus_if.pcEn !== 1'b0) begin fails++; $display("FAIL halt_pcEn_c0 got %b want 0", bus_if.pcEn); end
    step();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, k[0], ~k[0]);
      #2;
      tests++; if (bus_if.halt !== 1'b1) begin fails++; $display("FAIL halt_flag cyc %0d got %b want 1", k, bus_if.halt); end
      tests++; if ({bus_if.imemREN, bus_if.dmemREN, bus_if.dmemWEN, bus_if.pcEn, bus_if.err} !== 5'b0)
        begin fails++; $display("FAIL halt_outs cyc %0d got %b want 00000", k,
          {bus_if.imemREN, bus_if.dmemREN, bus_if.dmemWEN, bus_if.pcEn, bus_if.err}); end
      step();
    end
    #2;
    tests++; if (stall_cnt !== 2'd0) begin fails++; $display("FAIL halt_stall got %0d want 0", stall_cnt); end
    $display("[TB] halt transaction absorbed further hits");
  endtask

  task automatic test_timeout();
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    for (int k = 1; k <= 6; k++) begin
      logic [1:0] exp_stall;
      exp_stall = (k - 1 > 3) ? 2'd3 : 2'(k - 1);
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      tests++; if (bus_if.dmemREN !== 1'b1) begin fails++; $display("FAIL to_dmemREN cyc %0d got %b want 1", k, bus_if.dmemREN); end
      tests++; if (bus_if.err !== (k >= 5)) begin fails++; $display("FAIL to_err cyc %0d got %b want %b", k, bus_if.err, (k >= 5)); end
      tests++; if (stall_cnt !== exp_stall) begin fails++; $display("FAIL to_stall cyc %0d got %0d want %0d", k, stall_cnt, exp_stall); end
      step();
    end
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    tests++; if (bus_if.pcEn !== 1'b1) begin fails++; $display("FAIL to_pcEn got %b want 1", bus_if.pcEn); end
    step();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    tests++; if (bus_if.imemREN !== 1'b1) begin fails++; $display("FAIL to_back_fetch got %b want 1", bus_if.imemREN); end
    tests++; if (stall_cnt !== 2'd3) begin fails++; $display("FAIL to_stall_sat got %0d want 3", stall_cnt); end
    $display("[TB] timed-out load flagged and retired");
  endtask

  task automatic test_rst_in_data();
    do_reset();
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    #2;
    tests++; if (bus_if.dmemWEN !== 1'b1) begin fails++; $display("FAIL rstd_pre_wen got %b want 1", bus_if.dmemWEN); end
    tests++; if (stall_cnt !== 2'd2) begin fails++; $display("FAIL rstd_pre_stall got %0d want 2", stall_cnt); end
    step();
    rst = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    tests++; if (bus_if.dmemWEN !== 1'b0) begin fails++; $display("FAIL rstd_wen got %b want 0", bus_if.dmemWEN); end
    tests++; if (bus_if.err !== 1'b0) begin fails++; $display("FAIL rstd_err got %b want 0", bus_if.err); end
    tests++; if (stall_cnt !== 2'd0) begin fails++; $display("FAIL rstd_stall got %0d want 0", stall_cnt); end
    tests++; if (bus_if.imemREN !== 1'b1) begin fails++; $display("FAIL rstd_fetch got %b want 1", bus_if.imemREN); end
    tests++; if (bus_if.pcEn !== 1'b0) begin fails++; $display("FAIL dhit_fetch_pcEn got %b want 0", bus_if.pcEn); end
    step();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    tests++; if (bus_if.imemREN !== 1'b1) begin fails++; $display("FAIL dhit_fetch_state got %b want 1", bus_if.imemREN); end
    tests++; if (bus_if.err !== 1'b0) begin fails++; $display("FAIL dhit_fetch_err got %b want 0", bus_if.err); end
    $display("[TB] reset during store dropped the request");
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    tests++; if (bus_if.pcEn !== 1'b0) begin fails++; $display("FAIL b2b_ihit_in_data got %b want 0", bus_if.pcEn); end
    tests++; if (bus_if.imemREN !== 1'b0) begin fails++; $display("FAIL b2b_imemREN_data got %b want 0", bus_if.imemREN); end
    step();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    tests++; if (bus_if.pcEn !== 1'b1) begin fails++; $display("FAIL b2b_load_retire got %b want 1", bus_if.pcEn); end
    step();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    tests++; if (bus_if.pcEn !== 1'b1) begin fails++; $display("FAIL b2b_rtype_retire got %b want 1", bus_if.pcEn); end
    step();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    tests++; if (bus_if.pcEn !== 1'b0) begin fails++; $display("FAIL b2b_store_issue got %b want 0", bus_if.pcEn); end
    step();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    tests++; if ({bus_if.dmemWEN, bus_if.pcEn} !== 2'b11) begin fails++; $display("FAIL b2b_store_retire got %b want 11", {bus_if.dmemWEN, bus_if.pcEn}); end
    step();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    tests++; if ({bus_if.dmemWEN, bus_if.pcEn} !== 2'b00) begin fails++; $display("FAIL b2b_idle got %b want 00", {bus_if.dmemWEN, bus_if.pcEn}); end
    $display("[TB] back-to-back load/rtype/store sequence");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    test_reset();
    test_rtype();
    test_load();
    test_illegal_store();
    test_halt();
    test_timeout();
    test_rst_in_data();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
